eqn_result_collector: RTL

// - Downstream stage of the equation pipeline. Tags each operand issue, and waits LATENCY edges.
// - Then captures E into a small FIFO as a {seq, data} record.
// - Presents records on a valid/ready port, so a slow consumer can drain results.
// - The equation pipeline cannot stall. Records arriving to a full FIFO are dropped and flagged.

---
 rtl/eqn_pkg.sv | 12 +
 rtl/eqn_sync_fifo.sv | 42 ++++
 rtl/eqn_result_collector.sv | 85 ++++++++
 3 files changed

// File: rtl/eqn_pkg.sv
// Shared types for the equation-pipeline result path.
package eqn_pkg;

    localparam int unsigned EQN_DATA_W = 16;
    localparam int unsigned EQN_SEQ_W  = 8;

    typedef struct packed {
        logic [EQN_SEQ_W-1:0]  seq;
        logic [EQN_DATA_W-1:0] data;
    } eqn_rec_t;

endpackage

// File: rtl/eqn_sync_fifo.sv
// Single-clock FIFO of eqn_rec_t records; full/empty come from the occupancy count.
module eqn_sync_fifo
    import eqn_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  eqn_rec_t                 wdata,
    output eqn_rec_t                 rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    eqn_rec_t             mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/eqn_result_collector.sv
// Tags equation-pipeline issues, captures E LATENCY edges later as {seq, data},
// and queues records for a valid/ready consumer; captures into a full queue are dropped.
module eqn_result_collector
    import eqn_pkg::*;
#(
    parameter int unsigned DATA_W  = EQN_DATA_W,
    parameter int unsigned SEQ_W   = EQN_SEQ_W,
    parameter int unsigned LATENCY = 3,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_issue,
    input  logic [DATA_W-1:0]       E,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [SEQ_W-1:0]        out_seq,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    ovf,
    input  logic                    ovf_clr,
    output logic [7:0]              drop_cnt
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [LATENCY-1:0] tag_d;
    logic [SEQ_W-1:0]   seq;
    logic               capture_c;
    logic               pop_c;
    logic               full_c;
    logic               push_c;
    logic               drop_c;
    eqn_rec_t           wr_rec_c;
    eqn_rec_t           head_rec;

    // Tag delay line: the concat shifts in_issue into bit 0 and truncation drops the oldest tag.
    always_ff @(posedge clk) begin
        if (!rst) tag_d <= '0;
        else      tag_d <= LATENCY'({tag_d, in_issue});
    end

    assign capture_c = tag_d[LATENCY-1];
    assign pop_c     = out_valid & out_ready;
    assign full_c    = (count == CNT_W'(DEPTH));
    assign push_c    = capture_c & (~full_c | pop_c);
    assign drop_c    = capture_c & full_c & ~pop_c;

    always_comb begin
        wr_rec_c      = '0;
        wr_rec_c.seq  = EQN_SEQ_W'(seq);
        wr_rec_c.data = EQN_DATA_W'(E);
    end

    // Sequence advances on every capture, so drops show up as gaps in out_seq.
    always_ff @(posedge clk) begin
        if (!rst) begin
            seq      <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (capture_c) seq <= seq + SEQ_W'(1);
            if (drop_c)       ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
            if (drop_c && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    eqn_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .pop   (pop_c),
        .wdata (wr_rec_c),
        .rdata (head_rec),
        .count (count)
    );

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? DATA_W'(head_rec.data) : '0;
    assign out_seq   = out_valid ? SEQ_W'(head_rec.seq)   : '0;

endmodule
